// File: rtl/spi_slave_mem_bridge_pkg.sv
// Shared definitions for the SPI slave memory bridge: opcodes, FSM states, wire address size.
// Opcodes match spi_master so both ends speak the same command set.
package spi_slave_mem_bridge_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_RDSR  = 8'h05;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned ADDR_BYTES  = 2;
    localparam int unsigned WIRE_ADDR_W = ADDR_BYTES * BYTE_W;
    localparam int unsigned BIT_CNT_W   = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_WRITE,
        ST_READ,
        ST_IGNORE
    } state_e;

endpackage

// File: rtl/spi_slave_mem_bridge_if.sv
// Byte-wide synchronous memory port between the bridge (master) and a local SRAM (slave).
interface spi_slave_mem_bridge_if #(
    parameter int unsigned ADDR_WIDTH = 16
);
    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [7:0]            mem_wdata_o;
    logic [7:0]            mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/spi_slave_mem_bridge_sync.sv
// Synchronizers for SCLK/CS/MOSI into the core clock plus SCLK rise/fall pulse detection.
module spi_slave_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_core_i,
    input  logic rst_n_i,
    input  logic spi_sclk_i,
    input  logic spi_cs_i,
    input  logic spi_mosi_i,
    output logic sclk_rise_c,
    output logic sclk_fall_c,
    output logic cs_sync_o,
    output logic mosi_sync_o
);
    localparam int unsigned STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] sclk_q, sclk_d;
    logic [STAGES-1:0] cs_q,   cs_d;
    logic [STAGES-1:0] mosi_q, mosi_d;
    logic              sclk_prev_q, sclk_prev_d;

    always_comb begin
        sclk_d      = {sclk_q[STAGES-2:0], spi_sclk_i};
        cs_d        = {cs_q[STAGES-2:0],   spi_cs_i};
        mosi_d      = {mosi_q[STAGES-2:0], spi_mosi_i};
        sclk_prev_d = sclk_q[STAGES-1];
    end

    // CS chains reset to the deasserted level so reset never looks like a selection
    always_ff @(posedge clk_core_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sclk_q      <= '0;
            cs_q        <= '1;
            mosi_q      <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_q      <= sclk_d;
            cs_q        <= cs_d;
            mosi_q      <= mosi_d;
            sclk_prev_q <= sclk_prev_d;
        end
    end

    assign sclk_rise_c = sclk_q[STAGES-1] & ~sclk_prev_q;
    assign sclk_fall_c = ~sclk_q[STAGES-1] & sclk_prev_q;
    assign cs_sync_o   = cs_q[STAGES-1];
    assign mosi_sync_o = mosi_q[STAGES-1];

endmodule

// File: rtl/spi_slave_mem_bridge.sv
// SPI mode-0 slave bridging WRITE/READ bursts onto a byte-wide synchronous memory port.
// Optional status register read (opcode 0x05) built when SPI_SLAVE_STATUS_EN is defined.
module spi_slave_mem_bridge
    import spi_slave_mem_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk_core_i,
    input  logic                   rst_n_i,
    input  logic                   spi_sclk_i,
    input  logic                   spi_cs_i,
    input  logic                   spi_mosi_i,
    output logic                   spi_miso_o,
    output logic                   spi_miso_oe_o,
    spi_slave_mem_bridge_if.master mem,
    output logic                   busy_o
);

    logic rise_c, fall_c, cs_s, mosi_s;

    spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_core_i  (clk_core_i),
        .rst_n_i     (rst_n_i),
        .spi_sclk_i  (spi_sclk_i),
        .spi_cs_i    (spi_cs_i),
        .spi_mosi_i  (spi_mosi_i),
        .sclk_rise_c (rise_c),
        .sclk_fall_c (fall_c),
        .cs_sync_o   (cs_s),
        .mosi_sync_o (mosi_s)
    );

    state_e                 state_q,    state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q,  bit_cnt_d;
    logic [BYTE_W-2:0]      mosi_sh_q,  mosi_sh_d;
    logic [BYTE_W-1:0]      addr_hi_q,  addr_hi_d;
    logic                   is_write_q, is_write_d;
    logic [ADDR_WIDTH-1:0]  ptr_q,      ptr_d;
    logic [BYTE_W-1:0]      miso_sh_q,  miso_sh_d;
    logic                   miso_q,     miso_d;
    logic                   oe_q,       oe_d;
    logic                   req_q,      req_d;
    logic                   we_q,       we_d;
    logic [ADDR_WIDTH-1:0]  maddr_q,    maddr_d;
    logic [BYTE_W-1:0]      wdata_q,    wdata_d;
    logic                   busy_q,     busy_d;
    logic                   rd_load_q,  rd_load_d;

    logic [BYTE_W-1:0]      byte_c;
    logic                   byte_done_c;
    logic [WIRE_ADDR_W-1:0] wire_addr_c;
    logic [ADDR_WIDTH-1:0]  addr_c;

`ifdef SPI_SLAVE_STATUS_EN
    logic              illegal_q, illegal_d;
    logic              wdone_q,   wdone_d;
    logic              rdsr_q,    rdsr_d;
    logic [BYTE_W-1:0] status_c;
    assign status_c = {6'b0, illegal_q, wdone_q};
`endif

    assign byte_c      = {mosi_sh_q, mosi_s};
    assign byte_done_c = rise_c && (bit_cnt_q == BIT_CNT_W'(7));
    assign wire_addr_c = {addr_hi_q, byte_c};
    assign addr_c      = ADDR_WIDTH'(wire_addr_c);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        mosi_sh_d  = mosi_sh_q;
        addr_hi_d  = addr_hi_q;
        is_write_d = is_write_q;
        ptr_d      = ptr_q;
        miso_sh_d  = miso_sh_q;
        miso_d     = miso_q;
        oe_d       = oe_q;
        req_d      = 1'b0;
        we_d       = we_q;
        maddr_d    = maddr_q;
        wdata_d    = wdata_q;
        busy_d     = ~cs_s;
        rd_load_d  = req_q & ~we_q & (state_q == ST_READ);
`ifdef SPI_SLAVE_STATUS_EN
        illegal_d  = illegal_q;
        wdone_d    = wdone_q;
        rdsr_d     = rdsr_q;
`endif

        // Memory answers one clk after the strobe; drop it if the transfer was aborted
        if (rd_load_q && (state_q == ST_READ)) begin
            miso_sh_d = mem.mem_rdata_i;
        end

        if ((state_q != ST_IDLE) && cs_s) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            oe_d      = 1'b0;
            miso_d    = 1'b0;
`ifdef SPI_SLAVE_STATUS_EN
            if (rdsr_q) begin
                illegal_d = 1'b0;
                wdone_d   = 1'b0;
            end
            rdsr_d = 1'b0;
`endif
        end else begin
            if ((state_q != ST_IDLE) && rise_c) begin
                mosi_sh_d = byte_c[BYTE_W-2:0];
                bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    if (!cs_s) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = '0;
                    end
                end
                ST_CMD: begin
                    if (byte_done_c) begin
                        if ((byte_c == CMD_WRITE) || (byte_c == CMD_READ)) begin
                            state_d    = ST_ADDR_HI;
                            is_write_d = (byte_c == CMD_WRITE);
`ifdef SPI_SLAVE_STATUS_EN
                        end else if (byte_c == CMD_RDSR) begin
                            state_d   = ST_READ;
                            oe_d      = 1'b1;
                            miso_sh_d = status_c;
                            rdsr_d    = 1'b1;
`endif
                        end else begin
                            state_d = ST_IGNORE;
`ifdef SPI_SLAVE_STATUS_EN
                            illegal_d = 1'b1;
`endif
                        end
                    end
                end
                ST_ADDR_HI: begin
                    if (byte_done_c) begin
                        addr_hi_d = byte_c;
                        state_d   = ST_ADDR_LO;
                    end
                end
                ST_ADDR_LO: begin
                    if (byte_done_c) begin
                        if (is_write_q) begin
                            ptr_d   = addr_c;
                            state_d = ST_WRITE;
                        end else begin
                            req_d   = 1'b1;
                            we_d    = 1'b0;
                            maddr_d = addr_c;
                            ptr_d   = addr_c + ADDR_WIDTH'(1);
                            oe_d    = 1'b1;
                            state_d = ST_READ;
                        end
                    end
                end
                ST_WRITE: begin
                    if (byte_done_c) begin
                        req_d   = 1'b1;
                        we_d    = 1'b1;
                        maddr_d = ptr_q;
                        wdata_d = byte_c;
                        ptr_d   = ptr_q + ADDR_WIDTH'(1);
`ifdef SPI_SLAVE_STATUS_EN
                        wdone_d = 1'b1;
`endif
                    end
                end
                ST_READ: begin
                    if (fall_c) begin
                        miso_d    = miso_sh_q[BYTE_W-1];
                        miso_sh_d = {miso_sh_q[BYTE_W-2:0], 1'b0};
                    end
                    if (byte_done_c) begin
`ifdef SPI_SLAVE_STATUS_EN
                        if (rdsr_q) begin
                            miso_sh_d = status_c;
                        end else begin
                            req_d   = 1'b1;
                            we_d    = 1'b0;
                            maddr_d = ptr_q;
                            ptr_d   = ptr_q + ADDR_WIDTH'(1);
                        end
`else
                        req_d   = 1'b1;
                        we_d    = 1'b0;
                        maddr_d = ptr_q;
                        ptr_d   = ptr_q + ADDR_WIDTH'(1);
`endif
                    end
                end
                ST_IGNORE: begin
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_core_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            mosi_sh_q  <= '0;
            addr_hi_q  <= '0;
            is_write_q <= 1'b0;
            ptr_q      <= '0;
            miso_sh_q  <= '0;
            miso_q     <= 1'b0;
            oe_q       <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            maddr_q    <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            rd_load_q  <= 1'b0;
`ifdef SPI_SLAVE_STATUS_EN
            illegal_q  <= 1'b0;
            wdone_q    <= 1'b0;
            rdsr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            mosi_sh_q  <= mosi_sh_d;
            addr_hi_q  <= addr_hi_d;
            is_write_q <= is_write_d;
            ptr_q      <= ptr_d;
            miso_sh_q  <= miso_sh_d;
            miso_q     <= miso_d;
            oe_q       <= oe_d;
            req_q      <= req_d;
            we_q       <= we_d;
            maddr_q    <= maddr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            rd_load_q  <= rd_load_d;
`ifdef SPI_SLAVE_STATUS_EN
            illegal_q  <= illegal_d;
            wdone_q    <= wdone_d;
            rdsr_q     <= rdsr_d;
`endif
        end
    end

    assign spi_miso_o      = miso_q;
    assign spi_miso_oe_o   = oe_q;
    assign busy_o          = busy_q;
    assign mem.mem_req_o   = req_q;
    assign mem.mem_we_o    = we_q;
    assign mem.mem_addr_o  = maddr_q;
    assign mem.mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_spi_slave_mem_bridge.sv
// Directed bench for spi_slave_mem_bridge: SPI master driver, SRAM, and a strobe/content model.
module tb_spi_slave_mem_bridge;
    localparam int HALF = 60;

    logic clk = 1'b0;
    logic rst_n;
    logic sclk, cs, mosi;
    logic miso, oe, busy;

    spi_slave_mem_bridge_if #(.ADDR_WIDTH(16)) mem_if();

    spi_slave_mem_bridge #(.ADDR_WIDTH(16), .SYNC_STAGES(2)) dut (
        .clk_core_i    (clk),
        .rst_n_i       (rst_n),
        .spi_sclk_i    (sclk),
        .spi_cs_i      (cs),
        .spi_mosi_i    (mosi),
        .spi_miso_o    (miso),
        .spi_miso_oe_o (oe),
        .mem           (mem_if.master),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } strobe_t;

    strobe_t     exp_q[$];
    logic [7:0]  sram    [0:65535];
    logic [7:0]  ref_mem [0:65535];
    int          checks = 0;
    int          errors = 0;
    logic        ignore_win = 1'b0;
    logic        prev_req = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Local SRAM: read data registered, valid the clk after the strobe
    always @(posedge clk) begin
        if (mem_if.mem_req_o) begin
            if (mem_if.mem_we_o) sram[mem_if.mem_addr_o] <= mem_if.mem_wdata_o;
            else                 mem_if.mem_rdata_i <= sram[mem_if.mem_addr_o];
        end
    end

    // Every strobe must match the next expected transaction, in order
    always @(negedge clk) begin
        strobe_t e;
        if (rst_n) begin
            if (mem_if.mem_req_o) begin
                check("req_gap", 32'(prev_req), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got we=%0b addr=0x%0h expected none", mem_if.mem_we_o, mem_if.mem_addr_o);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_we", 32'(mem_if.mem_we_o), 32'(e.we));
                    check("strobe_addr", 32'(mem_if.mem_addr_o), 32'(e.addr));
                    if (e.we) check("strobe_wdata", 32'(mem_if.mem_wdata_o), 32'(e.data));
                end
            end
            if (!oe) check("miso_low_when_oe_low", 32'(miso), 32'd0);
            if (ignore_win) check("ignore_oe", 32'(oe), 32'd0);
            prev_req = mem_if.mem_req_o;
        end else begin
            prev_req = 1'b0;
        end
    end

    task automatic expect_write(input logic [15:0] a, input logic [7:0] d);
        strobe_t s;
        s.we = 1'b1; s.addr = a; s.data = d;
        exp_q.push_back(s);
        ref_mem[a] = d;
    endtask

    task automatic expect_read(input logic [15:0] a);
        strobe_t s;
        s.we = 1'b0; s.addr = a; s.data = 8'h00;
        exp_q.push_back(s);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            mosi = tx[i];
            #HALF;
            sclk = 1'b1;
            rx[i] = miso;
            #HALF;
            sclk = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        spi_bits(tx, 8, rx);
    endtask

    task automatic cs_begin();
        cs = 1'b0;
        #HALF;
    endtask

    task automatic cs_end();
        #HALF;
        cs = 1'b1;
        #(HALF * 2);
        check("pending_strobes", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"},  32'(miso), 32'd0);
        check({tag, "_oe"},    32'(oe), 32'd0);
        check({tag, "_req"},   32'(mem_if.mem_req_o), 32'd0);
        check({tag, "_we"},    32'(mem_if.mem_we_o), 32'd0);
        check({tag, "_addr"},  32'(mem_if.mem_addr_o), 32'd0);
        check({tag, "_wdata"}, 32'(mem_if.mem_wdata_o), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rx, rx2;
        for (int i = 0; i < 65536; i++) begin
            sram[i]    = 8'((i * 7 + 3) ^ (i >> 8));
            ref_mem[i] = sram[i];
        end
        sram[16'h0010] = 8'h5A; ref_mem[16'h0010] = 8'h5A;
        sram[16'h0011] = 8'hC3; ref_mem[16'h0011] = 8'hC3;
        sram[16'h0020] = 8'h77; ref_mem[16'h0020] = 8'h77;

        rst_n = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        #52;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        #100;

        // Single write
        expect_write(16'h1234, 8'hA5);
        cs_begin();
        spi_byte(8'h02, rx); spi_byte(8'h12, rx); spi_byte(8'h34, rx);
        check("busy_in_xfer", 32'(busy), 32'd1);
        spi_byte(8'hA5, rx);
        cs_end();
        check("sram_1234", 32'(sram[16'h1234]), 32'h0A5);
        check("busy_after_xfer", 32'(busy), 32'd0);

        // Read burst of two bytes; the second byte's completion prefetches 0x0012
        expect_read(16'h0010); expect_read(16'h0011); expect_read(16'h0012);
        cs_begin();
        spi_byte(8'h03, rx); spi_byte(8'h00, rx); spi_byte(8'h10, rx);
        spi_byte(8'h00, rx); spi_byte(8'h00, rx2);
        check("rd_byte0_lit", 32'(rx), 32'h05A);
        check("rd_byte1_lit", 32'(rx2), 32'h0C3);
        cs_end();

        // Write burst wrapping 0xFFFF -> 0x0000
        expect_write(16'hFFFF, 8'h11); expect_write(16'h0000, 8'h22);
        cs_begin();
        spi_byte(8'h02, rx); spi_byte(8'hFF, rx); spi_byte(8'hFF, rx);
        spi_byte(8'h11, rx); spi_byte(8'h22, rx);
        cs_end();
        check("sram_ffff", 32'(sram[16'hFFFF]), 32'h011);
        check("sram_0000", 32'(sram[16'h0000]), 32'h022);

        // Abort after 5 data bits: no strobe, original content survives
        cs_begin();
        spi_byte(8'h02, rx); spi_byte(8'h00, rx); spi_byte(8'h20, rx);
        spi_bits(8'hFF, 5, rx);
        cs_end();
        expect_read(16'h0020); expect_read(16'h0021);
        cs_begin();
        spi_byte(8'h03, rx); spi_byte(8'h00, rx); spi_byte(8'h20, rx);
        spi_byte(8'h00, rx);
        check("abort_readback_lit", 32'(rx), 32'h077);
        cs_end();

        // Illegal opcode: silent for the whole selection
        ignore_win = 1'b1;
        cs_begin();
        spi_byte(8'h9F, rx); spi_byte(8'h00, rx); spi_byte(8'h00, rx); spi_byte(8'h00, rx);
        check("illegal_rx", 32'(rx), 32'd0);
        cs_end();
        ignore_win = 1'b0;

`ifndef SPI_SLAVE_STATUS_EN
        // Without the status feature 0x05 is just another illegal opcode
        ignore_win = 1'b1;
        cs_begin();
        spi_byte(8'h05, rx); spi_byte(8'h00, rx);
        check("rdsr_disabled_rx", 32'(rx), 32'd0);
        cs_end();
        ignore_win = 1'b0;
`endif

        // Reset in the middle of a read data phase
        expect_read(16'h0010);
        cs_begin();
        spi_byte(8'h03, rx); spi_byte(8'h00, rx); spi_byte(8'h10, rx);
        spi_bits(8'h00, 4, rx);
        #4;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        #105;
        rst_n = 1'b1;
        #100;
        expect_write(16'h0040, 8'h3C);
        cs_begin();
        spi_byte(8'h02, rx); spi_byte(8'h00, rx); spi_byte(8'h40, rx); spi_byte(8'h3C, rx);
        cs_end();
        expect_read(16'h0040); expect_read(16'h0041);
        cs_begin();
        spi_byte(8'h03, rx); spi_byte(8'h00, rx); spi_byte(8'h40, rx);
        spi_byte(8'h00, rx);
        check("post_reset_readback", 32'(rx), 32'(ref_mem[16'h0040]));
        cs_end();

`ifdef SPI_SLAVE_STATUS_EN
        ignore_win = 1'b1;
        cs_begin();
        spi_byte(8'hAB, rx); spi_byte(8'h00, rx);
        cs_end();
        ignore_win = 1'b0;
        expect_write(16'h0050, 8'hAA);
        cs_begin();
        spi_byte(8'h02, rx); spi_byte(8'h00, rx); spi_byte(8'h50, rx); spi_byte(8'hAA, rx);
        cs_end();
        cs_begin();
        spi_byte(8'h05, rx); spi_byte(8'h00, rx); spi_byte(8'h00, rx2);
        check("rdsr_first", 32'(rx), 32'h03);
        check("rdsr_first_repeat", 32'(rx2), 32'h03);
        cs_end();
        cs_begin();
        spi_byte(8'h05, rx); spi_byte(8'h00, rx);
        check("rdsr_cleared", 32'(rx), 32'h00);
        cs_end();
`endif

        #100;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
